// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with per-frame debounce and a valid/ready key event port.
// Define KEYPAD_AUTOREPEAT_EN to emit repeat events while a single key stays held.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 25,
    parameter int REPEAT_RATE    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    input  logic       scan_en,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic [1:0] dbg_state
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef logic [DW-1:0] dwell_t;
    typedef logic [CW:0]   cnt_w_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PRESS_DB, ST_HELD, ST_REL_DB} state_t;
    typedef enum logic [1:0] {FR_NONE, FR_ONE, FR_MULTI} frame_t;

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("keypad_scan_ctrl: parameter out of range");
    end

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    logic [3:0] row_s1, row_s2;
    dwell_t     dwell_cnt;
    logic [1:0] col_idx;
    logic [1:0] acc_hits;   // keys seen so far this frame, saturating at 2
    logic [3:0] acc_code;
    logic       frame_done;
    frame_t     frame_res;
    logic [3:0] frame_code;

    logic       sample_now;
    logic [2:0] col_lows;
    logic [1:0] row_sel;
    logic [1:0] tot_hits;
    logic [3:0] tot_code;

    assign sample_now = (dwell_cnt == dwell_t'(SCAN_DIV - 1));
    assign col_out    = scan_en ? ~(4'b0001 << col_idx) : 4'hF;

    always_comb begin
        col_lows = 3'd0;
        row_sel  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2[r]) begin
                col_lows = col_lows + 3'd1;
                row_sel  = 2'(r);
            end
        end
        if (col_lows == 3'd0)                         tot_hits = acc_hits;
        else if (col_lows == 3'd1 && acc_hits == 2'd0) tot_hits = 2'd1;
        else                                           tot_hits = 2'd2;
        tot_code = (acc_hits == 2'd0) ? key_map(row_sel, col_idx) : acc_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1     <= 4'hF;
            row_s2     <= 4'hF;
            dwell_cnt  <= '0;
            col_idx    <= 2'd0;
            acc_hits   <= 2'd0;
            acc_code   <= 4'h0;
            frame_done <= 1'b0;
            frame_res  <= FR_NONE;
            frame_code <= 4'h0;
        end else begin
            row_s1     <= row_in;
            row_s2     <= row_s1;
            frame_done <= 1'b0;
            if (!scan_en) begin
                dwell_cnt <= '0;
                col_idx   <= 2'd0;
                acc_hits  <= 2'd0;
                acc_code  <= 4'h0;
            end else if (sample_now) begin
                dwell_cnt <= '0;
                col_idx   <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    frame_done <= 1'b1;
                    frame_res  <= (tot_hits == 2'd0) ? FR_NONE : (tot_hits == 2'd1) ? FR_ONE : FR_MULTI;
                    frame_code <= tot_code;
                    acc_hits   <= 2'd0;
                    acc_code   <= 4'h0;
                end else begin
                    acc_hits <= tot_hits;
                    acc_code <= tot_code;
                end
            end else begin
                dwell_cnt <= dwell_cnt + dwell_t'(1);
            end
        end
    end

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    cand, cand_nxt;
    logic          emit, ev_fire;
    cnt_w_t        cnt_inc;

    assign cnt_inc   = {1'b0, cnt} + cnt_w_t'(1);
    assign ev_fire   = emit && scan_en;
    assign dbg_state = state;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    typedef logic [RW:0] rep_w_t;
    logic [RW-1:0] rep_cnt, rep_cnt_nxt;
    logic          rep_armed, rep_armed_nxt;
    rep_w_t        rep_inc;
    assign rep_inc = {1'b0, rep_cnt} + rep_w_t'(1);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        emit      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_nxt   = rep_cnt;
        rep_armed_nxt = rep_armed;
`endif
        if (frame_done) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_nxt   = '0;
            rep_armed_nxt = 1'b0;
`endif
            case (state)
                ST_IDLE: if (frame_res == FR_ONE) begin
                    cand_nxt = frame_code;
                    cnt_nxt  = CW'(1);
                    if (DEBOUNCE_SCANS == 1) begin
                        emit      = 1'b1;
                        state_nxt = ST_HELD;
                    end else begin
                        state_nxt = ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (frame_res != FR_ONE) begin
                        state_nxt = ST_IDLE;
                    end else if (frame_code != cand) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = CW'(1);
                    end else if (cnt_inc >= cnt_w_t'(DEBOUNCE_SCANS)) begin
                        emit      = 1'b1;
                        state_nxt = ST_HELD;
                    end else begin
                        cnt_nxt = cnt_inc[CW-1:0];
                    end
                end
                ST_HELD: begin
                    if (frame_res == FR_NONE) begin
                        cnt_nxt   = CW'(1);
                        state_nxt = (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_REL_DB;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (frame_res == FR_ONE && frame_code == cand) begin
                        if (rep_inc >= rep_w_t'(rep_armed ? REPEAT_RATE : REPEAT_DELAY)) begin
                            emit          = 1'b1;
                            rep_armed_nxt = 1'b1;
                        end else begin
                            rep_cnt_nxt   = rep_inc[RW-1:0];
                            rep_armed_nxt = rep_armed;
                        end
                    end
`endif
                end
                default: begin
                    if (frame_res != FR_NONE)                     state_nxt = ST_HELD;
                    else if (cnt_inc >= cnt_w_t'(DEBOUNCE_SCANS)) state_nxt = ST_IDLE;
                    else                                          cnt_nxt = cnt_inc[CW-1:0];
                end
            endcase
        end
    end

    // Handshake: an event is taken on any cycle with key_valid && key_ready; key_valid and
    // key_code hold until then. A new event lands if the slot is free or being taken this
    // cycle, otherwise it is dropped and overflow latches (set beats ovf_clr).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= 4'h0;
            key_held  <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overflow  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            if (!scan_en) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
`endif
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                cand     <= cand_nxt;
                key_held <= (state_nxt == ST_HELD) || (state_nxt == ST_REL_DB);
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= rep_cnt_nxt;
                rep_armed <= rep_armed_nxt;
`endif
            end
            if (ev_fire && (!key_valid || key_ready)) begin
                key_valid <= 1'b1;
                key_code  <= cand_nxt;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (ev_fire && key_valid && !key_ready) overflow <= 1'b1;
            else if (ovf_clr)                        overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad switch model, frame-level reference model, directed key sequences.
module tb_keypad_scan_ctrl;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       scan_en;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overflow;
  logic       ovf_clr;
  logic [1:0] dbg_state;
  logic [15:0] pressed;   // bit r*4+c = key at row r, column c is down

  int n_vec = 0;
  int n_bad = 0;
  int ev_count = 0;
  logic [3:0] ev_last = 4'h0;
  int base;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out), .scan_en(scan_en),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
    .overflow(overflow), .ovf_clr(ovf_clr), .dbg_state(dbg_state)
  );

  // switch matrix: a closed key pulls its row low while its column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int code_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int   m_t = 0;
  bit   m_pend = 0;
  int   m_pend_res = -1;
  int   hist[$];
  bit   m_held = 0;
  bit   m_valid = 0;
  bit   m_ovf = 0;
  logic [3:0] m_code = 4'h0;

  // -1 = no key, -2 = several keys, otherwise the key code
  function automatic int frame_of(input logic [15:0] p);
    if ($countones(p) == 0) return -1;
    if ($countones(p) > 1) return -2;
    for (int i = 0; i < 16; i++) if (p[i]) return code_tab[i];
    return -1;
  endfunction

  task automatic model_step();
    bit hs, ev, all_one, all_none, ovf_set;
    logic [3:0] ev_code;
    if (!rst_n) begin
      m_t = 0; m_pend = 0; hist.delete();
      m_held = 0; m_valid = 0; m_ovf = 0; m_code = 4'h0;
      return;
    end
    hs = m_valid && key_ready;
    ev = 0;
    ev_code = 4'h0;
    if (!scan_en) begin
      m_t = 0; m_pend = 0; m_held = 0; hist.delete();
    end else begin
      if (m_pend) begin
        hist.push_back(m_pend_res);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB) begin
          all_one = (hist[0] >= 0);
          all_none = 1;
          foreach (hist[i]) begin
            if (hist[i] != hist[0]) all_one = 0;
            if (hist[i] != -1) all_none = 0;
          end
          if (!m_held && all_one) begin
            ev = 1; ev_code = 4'(hist[0]); m_held = 1;
          end else if (m_held && all_none) begin
            m_held = 0;
          end
        end
        m_pend = 0;
      end
      if (m_t % FRAME == FRAME - 1) begin
        m_pend = 1;
        m_pend_res = frame_of(pressed);
      end
      m_t++;
    end
    ovf_set = 0;
    if (ev) begin
      if (!m_valid || hs) begin m_valid = 1; m_code = ev_code; end
      else ovf_set = 1;
    end else if (hs) begin
      m_valid = 0;
    end
    if (ovf_set) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // accepted events as seen by the consumer
  initial forever begin
    @(posedge clk);
    if (rst_n && key_valid && key_ready) begin
      ev_count++;
      ev_last = key_code;
    end
  end

  // cycle-by-cycle comparison against the model
  initial forever begin
    logic [3:0] exp_col;
    @(negedge clk);
    #1;
    if (rst_n === 1'b1) begin
      exp_col = scan_en ? (4'hF ^ (4'b0001 << ((m_t / SD) % 4))) : 4'hF;
      check("col_out", col_out, exp_col);
      check("key_valid", key_valid, m_valid);
      check("key_held", key_held, m_held);
      check("overflow", overflow, m_ovf);
      if (m_valid) check("key_code", key_code, m_code);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] m, input int nf);
    pressed = m;
    cycles(nf * FRAME);
  endtask

  initial begin
    rst_n = 1'b0; scan_en = 1'b1; key_ready = 1'b1; ovf_clr = 1'b0; pressed = 16'h0;
    cycles(3);
    check("rst col_out", col_out, 4'hE);
    check("rst key_valid", key_valid, 0);
    check("rst key_held", key_held, 0);
    check("rst overflow", overflow, 0);
    check("rst key_code", key_code, 0);
    check("rst fsm idle", dbg_state, 0);
    rst_n = 1'b1;

    // column walk
    check("col c0", col_out, 4'hE);
    cycles(3);  check("col c3", col_out, 4'hE);
    cycles(1);  check("col c4", col_out, 4'hD);
    cycles(4);  check("col c8", col_out, 4'hB);
    cycles(4);  check("col c12", col_out, 4'h7);
    cycles(4);  check("col c16", col_out, 4'hE);
    check("walk no event", key_valid, 0);

    // clean press of '5'
    base = ev_count;
    pressed = 16'h0020;
    cycles(2 * FRAME);     check("5 not yet", key_valid, 0);
    cycles(1);             check("5 valid", key_valid, 1);
    check("5 code", key_code, 4'h5);
    cycles(4 * FRAME - 1); check("5 held", key_held, 1);
    pressed = 16'h0;
    cycles(2 * FRAME);     check("5 rel still held", key_held, 1);
    cycles(1);             check("5 released", key_held, 0);
    check("5 one event", ev_count - base, 1);
    check("5 last code", ev_last, 4'h5);
    cycles(FRAME - 1);

    // bouncing '0'
    base = ev_count;
    hold(16'h2000, 1); hold(16'h0, 1); hold(16'h2000, 3); hold(16'h0, 3);
    check("0 one event", ev_count - base, 1);
    check("0 code", ev_last, 4'h0);

    // '1' and 'A' together, then 'A' lifted
    base = ev_count;
    hold(16'h0009, 4);
    check("multi no event", ev_count - base, 0);
    pressed = 16'h0001;
    cycles(2 * FRAME);     check("1 not yet", key_valid, 0);
    cycles(1);             check("1 valid", key_valid, 1);
    check("1 code", key_code, 4'h1);
    cycles(FRAME - 1);
    hold(16'h0, 3);
    check("1 one event", ev_count - base, 1);

    // backpressure: '7' waits, '8' is dropped
    key_ready = 1'b0;
    hold(16'h0100, 3);
    check("7 pending", key_valid, 1);
    check("7 code", key_code, 4'h7);
    check("7 no ovf", overflow, 0);
    hold(16'h0, 3);
    hold(16'h0200, 3);
    check("8 dropped valid", key_valid, 1);
    check("8 dropped code", key_code, 4'h7);
    check("8 overflow", overflow, 1);
    pressed = 16'h0;
    key_ready = 1'b1;
    cycles(1);             check("7 taken", key_valid, 0);
    check("ovf sticky", overflow, 1);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    check("ovf cleared", overflow, 0);
    cycles(FRAME - 2);
    hold(16'h0, 2);

    // scan_en abort during debounce of '9'
    base = ev_count;
    pressed = 16'h0400;
    cycles(FRAME + 2);
    scan_en = 1'b0;
    #1;
    check("dis col_out", col_out, 4'hF);
    cycles(8);
    check("dis held", key_held, 0);
    check("dis no event", ev_count - base, 0);
    scan_en = 1'b1;
    cycles(2 * FRAME);     check("9 en not yet", key_valid, 0);
    cycles(1);             check("9 en valid", key_valid, 1);
    check("9 en code", key_code, 4'h9);
    cycles(FRAME - 1);
    hold(16'h0, 3);
    check("9 en one event", ev_count - base, 1);

    // reset abort during debounce of '9'
    base = ev_count;
    pressed = 16'h0400;
    cycles(FRAME + 2);
    rst_n = 1'b0;
    #1;
    check("rst2 col_out", col_out, 4'hE);
    check("rst2 valid", key_valid, 0);
    check("rst2 held", key_held, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(2 * FRAME);     check("9 rst not yet", key_valid, 0);
    cycles(1);             check("9 rst valid", key_valid, 1);
    check("9 rst code", key_code, 4'h9);
    cycles(FRAME - 1);
    hold(16'h0, 3);
    check("9 rst one event", ev_count - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x4 matrix keypad that feeds the calculator: drives one column at a time, samples the rows, debounces the result and delivers one event per keypress.
- Sits between the keypad pins and the calculator state machine.
- Output is a valid/ready event interface carrying a 4-bit key code in the calculator's encoding.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan frames needed to accept a press or a release; minimum 1.
- REPEAT_DELAY, 25: frames held before the first auto-repeat (optional feature only).
- REPEAT_RATE, 8: frames between later auto-repeats (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- row_in  in  4  keypad rows, active-low (pulled up), asynchronous to clk
- col_out  out  4  column drive, one-cold, active-low
- scan_en  in  1  1 = scanning enabled
- key_code  out  4  code of the pending event
- key_valid  out  1  event pending
- key_ready  in  1  consumer accepts the event when key_valid && key_ready
- key_held  out  1  a debounced key is currently down
- overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears overflow

Behaviour:
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, overflow=0. Dwell counter, column index and debounce FSM are cleared; FSM=IDLE. Reset mid-debounce discards the candidate key.
- Row synchroniser: row_in passes through a 2-flop synchroniser. Rows are sampled on the last cycle of each column dwell.
- Column sequence: col 0..3 gives col_out = 1110, 1101, 1011, 0111. Each column is driven for SCAN_DIV cycles. One frame = 4*SCAN_DIV cycles.
- Key position: synchronised row r low while column c is driven means position (r,c).
- Key code map (row 0 to 3, col 0 to 3):
  - row 0: 1, 2, 3, A
  - row 1: 4, 5, 6, B
  - row 2: 7, 8, 9, C
  - row 3: E, 0, F, D
- Frame result, produced at frame end: NONE (no key down), ONE(code) (exactly one key down), or MULTI (two or more keys down).
- Debounce FSM, evaluated once per frame end:
  - IDLE:
    - ONE(k): candidate=k, cnt=1, go to PRESS_DB.
    - If DEBOUNCE_SCANS=1, emit and go straight to HELD.
  - PRESS_DB:
    - ONE(same k): cnt++. When cnt reaches DEBOUNCE_SCANS, emit an event for k and go to HELD.
    - ONE(other): restart with the new candidate, cnt=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: cnt=1, go to REL_DB.
    - ONE or MULTI: stay. No rollover events.
  - REL_DB:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - ONE or MULTI: go back to HELD.
- key_held = 1 in HELD and REL_DB.
- Event timing: an emitted event sets key_valid and key_code on the cycle after the frame-end sample.
- Handshake:
  - key_valid and key_code stay stable until key_valid && key_ready; key_valid then drops the next cycle.
  - A new event that arrives while key_valid=1 and no handshake occurs in that cycle is dropped, and overflow is set.
  - If a handshake and a new event land in the same cycle, the new event is loaded and overflow stays unchanged.
- Overflow clear: ovf_clr clears overflow. If ovf_clr and a set happen in the same cycle, set wins.
- scan_en=0:
  - col_out=4'b1111.
  - Dwell counter and column index reset to 0.
  - FSM forced to IDLE and key_held=0.
  - A pending key_valid event is kept.
  - When scan_en returns, scanning restarts at column 0 with a fresh frame.
- Latency: a key that is clean from the start of a frame produces key_valid DEBOUNCE_SCANS*4*SCAN_DIV+1 cycles after that frame starts.

Optional Feature:
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, while the frame result is ONE(same code), a frame counter runs.
  - The first repeat event is emitted after REPEAT_DELAY frames, then one every REPEAT_RATE frames.
  - Repeats follow the same handshake and overflow rules as normal events.
  - The counter resets on any other frame result.
- Undefined: exactly one event per debounced press. REPEAT_DELAY and REPEAT_RATE are unused.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 cycles):
- Reset and scan: release rst_n, scan_en=1 -> col_out=1110, then 1101 at cycle 4, 1011 at 8, 0111 at 12, 1110 at 16. key_valid=0 throughout.
- Clean press: hold '5' (row 1, col 1) for 6 frames, key_ready=1 -> exactly one key_valid pulse with key_code=4'h5 at the end of frame 2. key_held falls 2 frames after release.
- Bounce: '0' down 1 frame, up 1 frame, down 3 frames -> exactly one event, code 4'h0.
- Multi-key: '1' and 'A' together for 4 frames, then 'A' released -> no event while both are down; event 4'h1 two frames after 'A' releases.
- Backpressure: key_ready=0, press '7' then '8' -> key_valid held with code 4'h7, '8' dropped, overflow=1. Then key_ready=1 gives a handshake; pulse ovf_clr -> overflow=0.
- Abort: assert rst_n low, or set scan_en=0, during PRESS_DB of '9' -> no event and col_out at its reset/idle value. After re-enabling, '9' needs 2 full new frames before its event.
